// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART core.
// Imported by the tick generator and the top-level TX/RX FSMs.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_RECOVER
    } rx_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick (rx_en) and bit tick (tx_en) generator.
// tx_en coincides with every 16th rx_en.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int RX_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rx_en_o,
    output logic tx_en_o
);

    localparam int CW = $clog2(RX_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(RX_DIV - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    logic [CW-1:0] div_q;
    logic [3:0]    tick_q;

    assign rx_en_o = (div_q == DIV_LAST);
    assign tx_en_o = rx_en_o && (tick_q == TICK_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            tick_q <= '0;
        end else if (rx_en_o) begin
            div_q  <= '0;
            tick_q <= tick_q + 4'd1;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_txrx_core.sv
// 8N1 UART: shared tick generator, serial transmitter and
// 16x-oversampling receiver between a byte interface and the pins.
module uart_txrx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tx_data_en,
    input  logic [7:0] tx_data_in,
    output logic       tx_finish,
    output logic       tx_busy,
    output logic       tx_serial_data,
    input  logic       rx_serial_data,
    output logic       rx_finish,
    output logic [7:0] rx_data,
    output logic       rx_frame_err
);

    localparam int SPB    = BAUD * OVERSAMPLE;
    localparam int RX_DIV = (CLK_FREQ + SPB / 2) / SPB;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] END_TICK = 4'(OVERSAMPLE - 1);

    logic rx_en;
    logic tx_en;

    uart_tick_gen #(
        .RX_DIV (RX_DIV)
    ) u_tick (
        .clk_i   (clk_in),
        .rst_i   (rst),
        .rx_en_o (rx_en),
        .tx_en_o (tx_en)
    );

    tx_state_t  tx_state_q;
    logic [7:0] tx_byte_q;
    logic [2:0] tx_idx_q;
    logic       tx_line_q;
    logic       tx_busy_q;
    logic       tx_fin_q;

    // A request in the finish cycle is dropped so a held level
    // cannot retrigger on the same clock the frame completes.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_byte_q  <= '0;
            tx_idx_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_fin_q   <= 1'b0;
        end else begin
            tx_fin_q <= 1'b0;
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (tx_data_en && !tx_fin_q) begin
                        tx_byte_q  <= tx_data_in;
                        tx_busy_q  <= 1'b1;
                        tx_state_q <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (tx_en) begin
                        tx_line_q  <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_en) begin
                        tx_line_q  <= tx_byte_q[0];
                        tx_idx_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_en) begin
                        if (tx_idx_q == LAST_BIT) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_idx_q  <= tx_idx_q + 3'd1;
                            tx_line_q <= tx_byte_q[tx_idx_q + 3'd1];
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_en) begin
                        tx_fin_q   <= 1'b1;
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_serial_data = tx_line_q;
    assign tx_busy        = tx_busy_q;
    assign tx_finish      = tx_fin_q;

    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_serial_data};
        end
    end

    assign rx_s = sync_q[1];

    rx_state_t  rx_state_q;
    logic [3:0] rx_cnt_q;
    logic [2:0] rx_idx_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_fin_q;
    logic       rx_err_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_fin_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_fin_q <= 1'b0;
            rx_err_q <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_en && !rx_s) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_en) begin
                        if (rx_cnt_q == MID_TICK) begin
                            rx_cnt_q   <= '0;
                            rx_idx_q   <= '0;
                            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_en) begin
                        if (rx_cnt_q == END_TICK) begin
                            rx_cnt_q   <= '0;
                            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                            rx_idx_q   <= rx_idx_q + 3'd1;
                            if (rx_idx_q == LAST_BIT) begin
                                rx_state_q <= RX_STOP;
                            end
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_en) begin
                        if (rx_cnt_q == END_TICK) begin
                            rx_cnt_q <= '0;
                            if (rx_s) begin
                                rx_data_q  <= rx_shift_q;
                                rx_fin_q   <= 1'b1;
                                rx_state_q <= RX_IDLE;
                            end else begin
                                rx_err_q   <= 1'b1;
                                rx_state_q <= RX_RECOVER;
                            end
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 4'd1;
                        end
                    end
                end
                RX_RECOVER: begin
                    if (rx_en && rx_s) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_finish    = rx_fin_q;
    assign rx_data      = rx_data_q;
    assign rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_uart_txrx_core.sv
// Directed + randomized loopback bench for uart_txrx_core with a
// frame-level reference model and a received-byte scoreboard.
module tb_uart_txrx_core;
    import uart_pkg::*;

    localparam int BIT_CLK = 432;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tx_data_en = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       tx_finish;
    logic       tx_busy;
    logic       tx_serial_data;
    logic       rx_serial_data;
    logic       rx_finish;
    logic [7:0] rx_data;
    logic       rx_frame_err;

    logic loop_en = 1'b1;
    logic rx_drv = 1'b1;

    assign rx_serial_data = loop_en ? tx_serial_data : rx_drv;

    uart_txrx_core dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .tx_data_en     (tx_data_en),
        .tx_data_in     (tx_data_in),
        .tx_finish      (tx_finish),
        .tx_busy        (tx_busy),
        .tx_serial_data (tx_serial_data),
        .rx_serial_data (rx_serial_data),
        .rx_finish      (rx_finish),
        .rx_data        (rx_data),
        .rx_frame_err   (rx_frame_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int err_cnt = 0;
    int rx_cyc = 0;
    int tx_cyc = 0;
    logic [7:0] rxq[$];
    int rd = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rx_finish) begin
            rx_cnt++;
            rx_cyc = cyc;
            rxq.push_back(rx_data);
        end
        if (tx_finish) begin
            tx_cnt++;
            tx_cyc = cyc;
        end
        if (rx_frame_err) err_cnt++;
    end

    // Frame bit k of an 8N1 frame: start, data LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return logic'((b >> (k - 1)) & 8'd1);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        while ((tx_busy || tx_finish) && k < 20000) begin
            @(negedge clk_in);
            k++;
        end
        check("idle_before_send", {31'd0, tx_busy}, 32'd0);
        tx_data_in = b;
        tx_data_en = 1'b1;
        @(negedge clk_in);
        tx_data_en = 1'b0;
    endtask

    task automatic wait_tx(input int base);
        int k = 0;
        while (tx_cnt == base && k < 6000) begin
            @(negedge clk_in);
            k++;
        end
        check("tx_finish_count", tx_cnt - base, 32'd1);
    endtask

    task automatic wait_line_low(output int at);
        int k = 0;
        while (tx_serial_data && k < 1000) begin
            @(negedge clk_in);
            k++;
        end
        at = cyc;
        check("start_edge", {31'd0, tx_serial_data}, 32'd0);
    endtask

    task automatic expect_rx(input logic [7:0] b);
        logic [31:0] obs;
        obs = (rxq.size() > rd) ? {24'd0, rxq[rd]} : 32'hDEAD;
        rd++;
        check("rx_byte", obs, {24'd0, b});
        last_good = b;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx_drv = (k == 9) ? stop : frame_bit(b, k);
            tick(BIT_CLK);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int c0, c1, fall, rb, tb0, eb, k;
        logic [7:0] r;
        logic [7:0] seq [4];
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'hA5; seq[3] = 8'h5A;

        rst = 1'b1;
        tick(3);
        check("rst_tx_line", {31'd0, tx_serial_data}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_tx_finish", {31'd0, tx_finish}, 32'd0);
        check("rst_rx_finish", {31'd0, rx_finish}, 32'd0);
        check("rst_rx_err", {31'd0, rx_frame_err}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;

        k = 0;
        while (!dut.u_tick.rx_en_o && k < 100) begin tick(1); k++; end
        c0 = cyc;
        tick(1);
        k = 0;
        while (!dut.u_tick.rx_en_o && k < 100) begin tick(1); k++; end
        check("rx_en_period", cyc - c0, 32'd27);
        k = 0;
        while (!dut.u_tick.tx_en_o && k < 1000) begin tick(1); k++; end
        c0 = cyc;
        tick(1);
        k = 0;
        while (!dut.u_tick.tx_en_o && k < 1000) begin tick(1); k++; end
        c1 = cyc;
        check("tx_en_period", c1 - c0, BIT_CLK);

        rb = rx_cnt;
        tb0 = tx_cnt;
        send(8'h0E);
        wait_line_low(fall);
        tick(BIT_CLK / 2);
        for (int b = 0; b < 10; b++) begin
            check($sformatf("line_bit%0d", b), {31'd0, tx_serial_data},
                  {31'd0, frame_bit(8'h0E, b)});
            tick(BIT_CLK);
        end
        check("lb_tx_count", tx_cnt - tb0, 32'd1);
        check("lb_rx_count", rx_cnt - rb, 32'd1);
        expect_rx(8'h0E);
        check("lb_rx_data", {24'd0, rx_data}, 32'h0E);
        check("lb_frame_len", tx_cyc - fall, 10 * BIT_CLK);
        check("lb_rx_lead", {31'd0, (tx_cyc - rx_cyc >= 150) &&
              (tx_cyc - rx_cyc <= 260)}, 32'd1);

        r = 8'($urandom);
        tb0 = tx_cnt;
        send(r);
        k = 0;
        while (!tx_finish && k < 6000) begin tick(1); k++; end
        check("fin_seen", {31'd0, tx_finish}, 32'd1);
        tx_data_in = 8'hEE;
        tx_data_en = 1'b1;
        tick(1);
        tx_data_en = 1'b0;
        check("en_on_finish_ignored", {31'd0, tx_busy}, 32'd0);
        check("fin_tx_count", tx_cnt - tb0, 32'd1);
        expect_rx(r);

        rb = rx_cnt;
        tb0 = tx_cnt;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            int base;
            b = (i < 4) ? seq[i] : 8'($urandom);
            base = tx_cnt;
            send(b);
            tick(2000);
            tx_data_in = 8'h11;
            tx_data_en = 1'b1;
            tick(1);
            tx_data_en = 1'b0;
            wait_tx(base);
            expect_rx(b);
        end
        tick(500);
        check("b2b_busy_after", {31'd0, tx_busy}, 32'd0);
        check("b2b_rx_count", rx_cnt - rb, 32'd5);
        check("b2b_tx_count", tx_cnt - tb0, 32'd5);

        loop_en = 1'b0;
        rb = rx_cnt;
        eb = err_cnt;
        rx_drv = 1'b0;
        tick(108);
        rx_drv = 1'b1;
        tick(1000);
        check("glitch_no_rx", rx_cnt - rb, 32'd0);
        check("glitch_no_err", err_cnt - eb, 32'd0);
        check("glitch_rx_idle", {29'd0, dut.rx_state_q}, {29'd0, RX_IDLE});

        drive_frame(8'h3C, 1'b0);
        tick(500);
        check("ferr_count", err_cnt - eb, 32'd1);
        check("ferr_no_rx", rx_cnt - rb, 32'd0);
        check("ferr_rx_kept", {24'd0, rx_data}, {24'd0, last_good});
        drive_frame(8'h81, 1'b1);
        tick(100);
        check("after_ferr_count", rx_cnt - rb, 32'd1);
        expect_rx(8'h81);
        check("after_ferr_data", {24'd0, rx_data}, 32'h81);

        loop_en = 1'b1;
        tick(500);
        rb = rx_cnt;
        tb0 = tx_cnt;
        eb = err_cnt;
        send(8'hC3);
        wait_line_low(fall);
        tick(5 * BIT_CLK + BIT_CLK / 2);
        check("pre_rst_line", {31'd0, tx_serial_data}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_line", {31'd0, tx_serial_data}, 32'd1);
        check("rst_async_busy", {31'd0, tx_busy}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(5000);
        check("abort_no_tx", tx_cnt - tb0, 32'd0);
        check("abort_no_rx", rx_cnt - rb, 32'd0);
        check("abort_no_err", err_cnt - eb, 32'd0);
        send(8'h5A);
        wait_tx(tb0);
        expect_rx(8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
